spi_mem_burst: RTL

- Parametrised serial memory slave with single and burst transfers, auto-incrementing address, range check and frame abort.
- Serial host drives `cs` (active-low frame) and `miso` (host-to-block serial input).
- Block returns read data on `mosi`, qualified by `ready`; `op_done` pulses at the end of each frame.
- Serial memory model and DUT for bus-level SPI verification benches.

---
 rtl/spi_mem_burst_pkg.sv | 19 +
 rtl/spi_mem_burst_if.sv | 13 +
 rtl/spi_mem_burst_shift_reg.sv | 35 +++
 rtl/spi_mem_burst.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/spi_mem_burst_pkg.sv
// Shared types for the serial burst memory slave: FSM state encoding and opcodes.
// Also imported by the transaction and scoreboard code of the verification side.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    LEN,
    WDATA,
    TURN,
    RDATA,
    DONE
  } state_t;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/spi_mem_burst_if.sv
// Serial frame bus between host (master) and burst memory (slave).
// cs is active low; the host drives cs/miso, the memory drives the rest.
interface spi_mem_burst_if;
  logic cs;
  logic miso;
  logic ready;
  logic mosi;
  logic op_done;
  logic err;

  modport master (output cs, miso, input ready, mosi, op_done, err);
  modport slave  (input cs, miso, output ready, mosi, op_done, err);
endinterface

// File: rtl/spi_mem_burst_shift_reg.sv
// DW-bit LSB-first shift register with parallel load, sync clear and bit counter.
// One cycle per bit; no backpressure, shifts whenever shift is high.
module spi_shift_reg #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic          shift,
  input  logic          ser_in,
  input  logic [DW-1:0] load_dat,
  output logic [DW-1:0] dat,
  output logic          last
);
  localparam int CW = $clog2(DW);

  logic [CW-1:0] cnt;

  assign last = (cnt == CW'(DW - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      dat <= '0;
      cnt <= '0;
    end else if (load) begin
      dat <= load_dat;
      cnt <= '0;
    end else if (shift) begin
      dat <= {ser_in, dat[DW-1:1]};
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_mem_burst.sv
// Serial memory slave: cmd/addr/len header then LEN+1 words written or read back-to-back.
// Read data first valid 1+1+AW+LW+1 cycles after cs low; no backpressure, frames abort on cs high.
module spi_mem_burst
  import spi_mem_pkg::*;
#(
  parameter int DW    = 8,
  parameter int AW    = 5,
  parameter int DEPTH = 32,
  parameter int LW    = 2
) (
  input  logic           clk,
  input  logic           rst,
  spi_mem_burst_if.slave bus
);
  localparam int FW = $clog2((AW > LW) ? AW : LW) + 1;

  state_t        state, state_nxt;
  logic [AW-1:0] addr, addr_inc;
  logic [LW-1:0] len, wcnt;
  logic [FW-1:0] fcnt;
  logic          is_wr, armed, addr_ok, last_word, abort;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] wr_dat, rd_dat, rd_load_dat, wr_word;
  logic          wr_shift, wr_clr, wr_last;
  logic          rd_load, rd_shift, rd_clr, rd_last;
  logic          mem_we;
  logic          ready_q, op_done_q, err_q;
  logic          unused_bits;

  assign addr_ok   = ({1'b0, addr} < (AW + 1)'(DEPTH));
  // Out-of-range addresses stick: no increment, so the whole frame stays out of range.
  assign addr_inc  = !addr_ok ? addr : (addr == AW'(DEPTH - 1)) ? '0 : addr + 1'b1;
  assign last_word = (wcnt == len);
  assign abort     = bus.cs && (state != IDLE) && (state != DONE);
  assign wr_word   = {bus.miso, wr_dat[DW-1:1]};
  assign mem_we    = !rst && (state == WDATA) && wr_last && !abort && addr_ok;
  assign wr_clr    = (state_nxt == IDLE);
  assign rd_clr    = (state_nxt == IDLE) || (state_nxt == DONE);

  assign bus.ready   = ready_q;
  assign bus.mosi    = rd_dat[0];
  assign bus.op_done = op_done_q;
  assign bus.err     = err_q;
  assign unused_bits = ^{wr_dat[0], rd_dat[DW-1:1]};

  spi_shift_reg #(.DW(DW)) u_wr (
    .clk(clk), .rst(rst), .clr(wr_clr), .load(1'b0), .shift(wr_shift),
    .ser_in(bus.miso), .load_dat('0), .dat(wr_dat), .last(wr_last)
  );

  spi_shift_reg #(.DW(DW)) u_rd (
    .clk(clk), .rst(rst), .clr(rd_clr), .load(rd_load), .shift(rd_shift),
    .ser_in(1'b0), .load_dat(rd_load_dat), .dat(rd_dat), .last(rd_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    wr_shift    = 1'b0;
    rd_load     = 1'b0;
    rd_shift    = 1'b0;
    rd_load_dat = '0;
    case (state)
      IDLE:  if (!bus.cs && armed) state_nxt = CMD;
      CMD:   state_nxt = ADDR;
      ADDR:  if (fcnt == FW'(AW - 1)) state_nxt = LEN;
      LEN:   if (fcnt == FW'(LW - 1)) state_nxt = (is_wr == OP_WRITE) ? WDATA : TURN;
      WDATA: begin
        wr_shift = 1'b1;
        if (wr_last && last_word) state_nxt = DONE;
      end
      TURN: begin
        rd_load     = 1'b1;
        rd_load_dat = addr_ok ? mem[addr] : '0;
        state_nxt   = RDATA;
      end
      RDATA: begin
        if (!rd_last) begin
          rd_shift = 1'b1;
        end else if (last_word) begin
          state_nxt = DONE;
        end else begin
          rd_load     = 1'b1;
          rd_load_dat = addr_ok ? mem[addr_inc] : '0;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      len       <= '0;
      wcnt      <= '0;
      fcnt      <= '0;
      is_wr     <= 1'b0;
      armed     <= 1'b0;
      ready_q   <= 1'b0;
      op_done_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ready_q   <= (state_nxt == RDATA);
      op_done_q <= (state_nxt == DONE);
      // A new frame needs cs seen high since the previous start.
      if (bus.cs) armed <= 1'b1;
      case (state)
        IDLE: begin
          fcnt <= '0;
          wcnt <= '0;
          if (state_nxt == CMD) begin
            armed <= 1'b0;
            err_q <= 1'b0;
          end
        end
        CMD:  is_wr <= bus.miso;
        ADDR: begin
          addr <= (addr >> 1) | (AW'(bus.miso) << (AW - 1));
          fcnt <= (fcnt == FW'(AW - 1)) ? '0 : fcnt + 1'b1;
        end
        LEN: begin
          len  <= (len >> 1) | (LW'(bus.miso) << (LW - 1));
          fcnt <= fcnt + 1'b1;
          if ((fcnt == FW'(LW - 1)) && !addr_ok && !abort) err_q <= 1'b1;
        end
        WDATA: if (wr_last && !abort) begin
          addr <= addr_inc;
          wcnt <= wcnt + 1'b1;
        end
        RDATA: if (rd_last && !abort) begin
          addr <= addr_inc;
          wcnt <= wcnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[addr] <= wr_word;
  end

endmodule
